rnn_dot_sequencer: RTL and testbench

Downstream consumer of the RNN node's weight/state RAM. On start it sweeps read addresses 0..len-1 and absorbs the RAM's one-cycle registered read latency. It computes two signed fixed-point dot products per element: hsum = Σ(W·H + U·X) and ysum = Σ(V·H). Results are rounded down, saturated to 32 bits and held for the activation stage, with a done pulse.

---
 rtl/rnn_pkg.sv | 13 +
 rtl/rnn_mac_lane.sv | 51 +++++
 rtl/rnn_dot_sequencer.sv | 109 ++++++++++
 tb/tb_rnn_dot_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rnn_pkg.sv
// Shared widths, FSM states and saturation limits for the RNN dot-product sequencer.
package rnn_pkg;
  localparam int RAM_DEPTH = 512;
  localparam int ADDR_W    = $clog2(RAM_DEPTH);
  localparam int DATA_W    = 32;
  localparam int FRAC      = 16;
  localparam int ACC_W     = 2*DATA_W + ADDR_W - 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/rnn_mac_lane.sv
// One multiply-accumulate lane: registered products, wide accumulator and
// a floor-shifted, saturated view of the accumulator's next value.
module rnn_mac_lane #(
  parameter int DATA_W = rnn_pkg::DATA_W,
  parameter int FRAC   = rnn_pkg::FRAC,
  parameter int ACC_W  = rnn_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load,
  input  logic                     accum,
  input  logic signed [DATA_W-1:0] a0,
  input  logic signed [DATA_W-1:0] b0,
  input  logic signed [DATA_W-1:0] a1,
  input  logic signed [DATA_W-1:0] b1,
  output logic signed [DATA_W-1:0] result
);
  import rnn_pkg::*;

  localparam logic signed [ACC_W-1:0] SatHi = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] SatLo = ACC_W'(SAT_MIN);

  logic signed [2*DATA_W-1:0] prod0, prod1;
  logic signed [ACC_W-1:0]    acc, accNext, shifted;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prod0 <= '0;
      prod1 <= '0;
      acc   <= '0;
    end else begin
      if (load) begin
        prod0 <= (2*DATA_W)'(a0) * (2*DATA_W)'(b0);
        prod1 <= (2*DATA_W)'(a1) * (2*DATA_W)'(b1);
      end
      acc <= accNext;
    end
  end

  // The result looks through this cycle's accumulate so the owner can
  // capture the final sum on the same edge that the last term lands.
  always_comb begin
    accNext = acc;
    if (accum) accNext = acc + ACC_W'(prod0) + ACC_W'(prod1);
    shifted = accNext >>> FRAC;
    result  = shifted[DATA_W-1:0];
    if (shifted > SatHi)      result = SatHi[DATA_W-1:0];
    else if (shifted < SatLo) result = SatLo[DATA_W-1:0];
  end
endmodule

// File: rtl/rnn_dot_sequencer.sv
// Sweeps the weight/state RAM and produces the saturated hidden and output
// dot products for the activation stage.
module rnn_dot_sequencer #(
  parameter int ADDR_W = rnn_pkg::ADDR_W,
  parameter int DATA_W = rnn_pkg::DATA_W,
  parameter int FRAC   = rnn_pkg::FRAC,
  parameter int ACC_W  = rnn_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] readport,
  input  logic [DATA_W-1:0] readW,
  input  logic [DATA_W-1:0] readH,
  input  logic [DATA_W-1:0] readU,
  input  logic [DATA_W-1:0] readX,
  input  logic [DATA_W-1:0] readV,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hsum,
  output logic [DATA_W-1:0] ysum
);
  import rnn_pkg::*;

  state_t state, stateNext;
  logic [ADDR_W:0] counter, lenReg;
  logic v0, v1, v2, accept, clearAcc;
  logic signed [DATA_W-1:0] hNext, yNext;

  assign v0       = (state == ISSUE);
  assign clearAcc = accept && (len != '0);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign readport = counter[ADDR_W-1:0];

  // DRAIN exits once no read data is still in flight; the product stage
  // may still be accumulating, and that edge is also the capture edge.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          stateNext = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE:   if (counter == lenReg - 1'b1) stateNext = DRAIN;
      DRAIN:   if (!v1) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      lenReg  <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      hsum    <= '0;
      ysum    <= '0;
    end else begin
      state <= stateNext;
      v1    <= v0;
      v2    <= v1;
      if (clearAcc) begin
        lenReg  <= len;
        counter <= '0;
        v1      <= 1'b0;
        v2      <= 1'b0;
      end else if (v0 && stateNext == ISSUE) begin
        counter <= counter + 1'b1;
      end
      if (stateNext == DONE) begin
        hsum <= (state == IDLE) ? '0 : hNext;
        ysum <= (state == IDLE) ? '0 : yNext;
      end
    end
  end

  rnn_mac_lane #(.DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(ACC_W)) hLane (
    .clk    (clk),
    .reset  (reset),
    .clear  (clearAcc),
    .load   (v1),
    .accum  (v2),
    .a0     (readW),
    .b0     (readH),
    .a1     (readU),
    .b1     (readX),
    .result (hNext)
  );

  rnn_mac_lane #(.DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(ACC_W)) yLane (
    .clk    (clk),
    .reset  (reset),
    .clear  (clearAcc),
    .load   (v1),
    .accum  (v2),
    .a0     (readV),
    .b0     (readH),
    .a1     ('0),
    .b1     ('0),
    .result (yNext)
  );
endmodule

// File: tb/tb_rnn_dot_sequencer.sv
// Table-driven bench for rnn_dot_sequencer with a registered-read RAM model
// and a result scoreboard, plus hand sequences for abort and ignored starts.
module tb_rnn_dot_sequencer;
  localparam int AW = 9;
  localparam int DW = 32;

  typedef struct {
    int          len;
    logic [31:0] w, h, u, x, v;
    logic [31:0] expH, expY;
    int          expLat;
  } vec_t;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] y;
  } result_t;

  logic clk = 1'b0;
  logic reset, start;
  logic [AW:0] len;
  logic [AW-1:0] readport;
  logic [DW-1:0] readW, readH, readU, readX, readV;
  logic busy, done;
  logic [DW-1:0] hsum, ysum;

  logic [DW-1:0] memW [512];
  logic [DW-1:0] memH [512];
  logic [DW-1:0] memU [512];
  logic [DW-1:0] memX [512];
  logic [DW-1:0] memV [512];

  result_t sb[$];
  vec_t    vecs[9];
  int nCompared = 0;
  int nMismatch = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    readW <= memW[readport];
    readH <= memH[readport];
    readU <= memU[readport];
    readX <= memX[readport];
    readV <= memV[readport];
  end

  rnn_dot_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .readport (readport),
    .readW    (readW),
    .readH    (readH),
    .readU    (readU),
    .readX    (readX),
    .readV    (readV),
    .busy     (busy),
    .done     (done),
    .hsum     (hsum),
    .ysum     (ysum)
  );

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int l, input logic [31:0] w, h, u, x, v,
                              input logic [31:0] eh, ey, input int lat);
    vec_t r;
    r.len = l; r.w = w; r.h = h; r.u = u; r.x = x; r.v = v;
    r.expH = eh; r.expY = ey; r.expLat = lat;
    return r;
  endfunction

  task automatic fillMem(input vec_t t);
    for (int i = 0; i < 512; i++) begin
      memW[i] = t.w; memH[i] = t.h; memU[i] = t.u; memX[i] = t.x; memV[i] = t.v;
    end
  endtask

  // Drives one start pulse from an IDLE cycle and records the expected result
  task automatic applyStimulus(input vec_t t);
    result_t e;
    fillMem(t);
    start = 1'b1;
    len   = (AW+1)'(t.len);
    e.h = t.expH;
    e.y = t.expY;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Follows the sweep cycle by cycle; returns in the IDLE cycle after done
  task automatic checkOutput(input string tag, input vec_t t, input int injectAt);
    int k = 1;
    int doneAt = -1;
    bit sweepOk = 1'b1;
    bit busyOk = 1'b1;
    result_t e;
    while (k <= t.len + 20) begin
      if (injectAt > 0 && k == injectAt) begin start = 1'b1; len = 10'd2; end
      if (injectAt > 0 && k == injectAt + 1) start = 1'b0;
      if (k <= t.len && readport !== AW'(k - 1)) sweepOk = 1'b0;
      if (done === 1'b1) begin
        doneAt = k;
        break;
      end
      if (busy !== 1'b1) busyOk = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    checkValue({tag, "_doneLatency"}, doneAt, t.expLat);
    checkValue({tag, "_readportSweep"}, {31'b0, sweepOk}, 32'd1);
    checkValue({tag, "_busyDuringRun"}, {31'b0, busyOk & busy}, 32'd1);
    if (sb.size() == 0) begin
      checkValue({tag, "_scoreboardEmpty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      checkValue({tag, "_hsum"}, hsum, e.h);
      checkValue({tag, "_ysum"}, ysum, e.y);
      @(posedge clk); #1;
      checkValue({tag, "_donePulseEnds"}, {31'b0, done}, 32'd0);
      checkValue({tag, "_busyClears"}, {31'b0, busy}, 32'd0);
      checkValue({tag, "_hsumHeld"}, hsum, e.h);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int extraDones;
    bit abortedDone;
    vec_t one, busyVec;

    vecs[0] = mk(1,   32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00020000, 32'h00010000, 4);
    vecs[1] = mk(1,   32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4);
    vecs[2] = mk(4,   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        32'h0,        32'h0,        32'h7FFFFFFF, 32'h00000000, 7);
    vecs[3] = mk(1,   32'h80000000, 32'h7FFFFFFF, 32'h0,        32'h0,        32'h0,        32'h80000000, 32'h00000000, 4);
    vecs[4] = mk(1,   32'hFFFF0000, 32'h00008000, 32'h0,        32'h0,        32'h0,        32'hFFFF8000, 32'h00000000, 4);
    vecs[5] = mk(0,   32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000, 1);
    vecs[6] = mk(512, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h04000000, 32'h02000000, 515);
    vecs[7] = mk(3,   32'h00020000, 32'h00018000, 32'hFFFF0000, 32'h00008000, 32'h00030000, 32'h00078000, 32'h000D8000, 6);
    vecs[8] = mk(2,   32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00040000, 32'h00020000, 5);

    reset = 1'b1;
    start = 1'b0;
    len   = '0;
    fillMem(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    checkValue("reset_busy", {31'b0, busy}, 32'd0);
    checkValue("reset_done", {31'b0, done}, 32'd0);
    checkValue("reset_hsum", hsum, 32'd0);
    checkValue("reset_ysum", ysum, 32'd0);
    checkValue("reset_readport", 32'(readport), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Every vector starts in the IDLE cycle right after the previous done
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i], 0);
    end

    $display("[TB] start while busy");
    busyVec = mk(5, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h000A0000, 32'h00050000, 8);
    applyStimulus(busyVec);
    checkOutput("busyStart", busyVec, 3);
    extraDones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) extraDones++;
      @(posedge clk); #1;
    end
    checkValue("busyStart_noSecondDone", extraDones, 32'd0);

    $display("[TB] reset mid-sweep");
    fillMem(vecs[0]);
    start = 1'b1;
    len   = 10'd100;
    @(posedge clk); #1;
    start = 1'b0;
    abortedDone = 1'b0;
    for (int c = 1; c < 40; c++) begin
      if (done === 1'b1) abortedDone = 1'b1;
      @(posedge clk); #1;
    end
    checkValue("abort_busyBeforeReset", {31'b0, busy}, 32'd1);
    checkValue("abort_noEarlyDone", {31'b0, abortedDone}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkValue("abort_busy", {31'b0, busy}, 32'd0);
    checkValue("abort_done", {31'b0, done}, 32'd0);
    checkValue("abort_hsum", hsum, 32'd0);
    checkValue("abort_ysum", ysum, 32'd0);
    checkValue("abort_readport", 32'(readport), 32'd0);
    one = vecs[8];
    applyStimulus(one);
    checkOutput("afterAbort", one, 0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
